// File: rtl/snn_seq_pkg.sv
// Shared types and constants for the synapse weight sequencer.
//   seq_state_e    : sequencer FSM states
//   DRAIN_CYCLES   : cycles spent waiting for the last read to land on weightData
//   MEM_RD_LATENCY : weight memory read latency (data valid one cycle after memRdEn)
package snn_seq_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    DRAIN  = 2'd2,
    UPDATE = 2'd3
  } seq_state_e;

  localparam int unsigned DRAIN_CYCLES   = 2;
  localparam int unsigned MEM_RD_LATENCY = 1;
  localparam int unsigned DRAIN_CNT_W    = 2;

endpackage

// File: rtl/spike_priority_encoder.sv
// Lowest-set-bit finder over the spike snapshot (used by the skip-zero scan).
// Ports:
//   spikes_i        : spike vector to search
//   lowest_idx_c_o  : index of the lowest set bit (0 when none set), combinational
//   any_set_c_o     : at least one bit set, combinational
module spike_priority_encoder #(
  parameter int unsigned NUM_INPUT  = 64,
  parameter int unsigned ADDR_WIDTH = $clog2(NUM_INPUT)
) (
  input  logic [NUM_INPUT-1:0]  spikes_i,
  output logic [ADDR_WIDTH-1:0] lowest_idx_c_o,
  output logic                  any_set_c_o
);

  // Descending walk so the lowest set index is the last one written.
  always_comb begin
    lowest_idx_c_o = '0;
    for (int i = NUM_INPUT - 1; i >= 0; i--) begin
      if (spikes_i[i]) lowest_idx_c_o = ADDR_WIDTH'(i);
    end
  end

  assign any_set_c_o = |spikes_i;

endmodule

// File: rtl/synapse_weight_sequencer.sv
// Synapse weight sequencer: snapshots a spike vector on start, reads the weight
// of every spiking input from weight memory in ascending index order, streams
// the weights (zero when not valid) to the neuron, then pulses updateEnable.
// Optional build macro SPIKE_SKIP_ZERO_EN: scan only the set bits of the
// snapshot instead of walking every index.
// Ports:
//   clk, reset    : clock (rising edge), asynchronous active-low reset
//   start         : timestep request, accepted only when idle
//   inSpikes      : spike vector, captured on an accepted start
//   memRdEn/Addr  : weight memory read strobe and address (input index)
//   memRdData     : read data, valid one cycle after memRdEn
//   weightData    : weight to the neuron, 0 unless weightValid
//   weightValid   : weightData carries a fetched weight
//   updateEnable  : one-cycle pulse after the last weight
//   busy          : sequencer not idle
//   spikeCount    : reads issued this timestep, held until the next start
module synapse_weight_sequencer
  import snn_seq_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned NUM_INPUT  = 64,
  parameter int unsigned ADDR_WIDTH = $clog2(NUM_INPUT)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [NUM_INPUT-1:0]  inSpikes,
  output logic                  memRdEn,
  output logic [ADDR_WIDTH-1:0] memAddr,
  input  logic [DATA_WIDTH-1:0] memRdData,
  output logic [DATA_WIDTH-1:0] weightData,
  output logic                  weightValid,
  output logic                  updateEnable,
  output logic                  busy,
  output logic [ADDR_WIDTH:0]   spikeCount
);

  localparam int unsigned CNT_W = ADDR_WIDTH + 1;

  seq_state_e             state_q, state_d;
  logic [NUM_INPUT-1:0]   snap_q, snap_d;
  logic [ADDR_WIDTH-1:0]  idx_q, idx_d;
  logic [DRAIN_CNT_W-1:0] drain_q, drain_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic                   rd_en_q, rd_en_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic                   upd_q, upd_d;
  logic                   busy_q, busy_d;
  logic                   rd_pending_q;
  logic [DATA_WIDTH-1:0]  wdata_q;
  logic                   wvalid_q;

`ifdef SPIKE_SKIP_ZERO_EN
  logic [NUM_INPUT-1:0]  enc_vec;
  logic [ADDR_WIDTH-1:0] enc_idx;
  logic                  enc_any;

  // Idle searches the live input so the first read issues on the accepting edge.
  assign enc_vec = (state_q == IDLE) ? inSpikes : snap_q;

  spike_priority_encoder #(
    .NUM_INPUT  (NUM_INPUT),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_enc (
    .spikes_i       (enc_vec),
    .lowest_idx_c_o (enc_idx),
    .any_set_c_o    (enc_any)
  );
`endif

  // Next-state logic; output registers are loaded from the next state so the
  // read strobe and update pulse line up with the state they belong to.
  always_comb begin
    state_d = state_q;
    snap_d  = snap_q;
    idx_d   = idx_q;
    drain_d = drain_q;
    count_d = count_q;
    if (rd_en_q) count_d = count_q + CNT_W'(1);

    case (state_q)
      IDLE: begin
        if (start) begin
          count_d = '0;
`ifdef SPIKE_SKIP_ZERO_EN
          if (enc_any) begin
            state_d = SCAN;
            idx_d   = enc_idx;
            snap_d  = inSpikes & ~(NUM_INPUT'(1) << enc_idx);
          end else begin
            state_d = DRAIN;
            drain_d = '0;
            snap_d  = '0;
          end
`else
          state_d = SCAN;
          idx_d   = '0;
          snap_d  = inSpikes;
`endif
        end
      end
      SCAN: begin
`ifdef SPIKE_SKIP_ZERO_EN
        // snap_q holds only the bits not yet issued.
        if (enc_any) begin
          idx_d  = enc_idx;
          snap_d = snap_q & ~(NUM_INPUT'(1) << enc_idx);
        end else begin
          state_d = DRAIN;
          drain_d = '0;
        end
`else
        if (idx_q == ADDR_WIDTH'(NUM_INPUT - 1)) begin
          state_d = DRAIN;
          drain_d = '0;
        end else begin
          idx_d = idx_q + ADDR_WIDTH'(1);
        end
`endif
      end
      DRAIN: begin
        if (drain_q == DRAIN_CNT_W'(DRAIN_CYCLES - 1)) state_d = UPDATE;
        else drain_d = drain_q + DRAIN_CNT_W'(1);
      end
      UPDATE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase

`ifdef SPIKE_SKIP_ZERO_EN
    rd_en_d = (state_d == SCAN);
`else
    rd_en_d = (state_d == SCAN) && snap_d[idx_d];
`endif
    addr_d = (state_d == SCAN) ? idx_d : '0;
    upd_d  = (state_d == UPDATE);
    busy_d = (state_d != IDLE);
  end

  // FSM and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      snap_q  <= '0;
      idx_q   <= '0;
      drain_q <= '0;
      count_q <= '0;
      rd_en_q <= 1'b0;
      addr_q  <= '0;
      upd_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      snap_q  <= snap_d;
      idx_q   <= idx_d;
      drain_q <= drain_d;
      count_q <= count_d;
      rd_en_q <= rd_en_d;
      addr_q  <= addr_d;
      upd_q   <= upd_d;
      busy_q  <= busy_d;
    end
  end

  // Read return pipeline; weightData is zeroed when idle since the neuron
  // accumulates it every cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_pending_q <= 1'b0;
      wdata_q      <= '0;
      wvalid_q     <= 1'b0;
    end else begin
      rd_pending_q <= rd_en_q;
      wdata_q      <= rd_pending_q ? memRdData : '0;
      wvalid_q     <= rd_pending_q;
    end
  end

  assign memRdEn      = rd_en_q;
  assign memAddr      = addr_q;
  assign weightData   = wdata_q;
  assign weightValid  = wvalid_q;
  assign updateEnable = upd_q;
  assign busy         = busy_q;
  assign spikeCount   = count_q;

endmodule
